// File: rtl/tetris_pkg.sv
// Shared constants and types for the tetris input front end.
package tetris_pkg;

  // Button bit positions within btn_raw
  localparam int BTN_LEFT      = 0;
  localparam int BTN_RIGHT     = 1;
  localparam int BTN_DOWN      = 2;
  localparam int BTN_DROP      = 3;
  localparam int BTN_ROT_RIGHT = 4;
  localparam int BTN_ROT_LEFT  = 5;
  localparam int NUM_BTN       = 6;

  // Default timing for a 50 MHz clk: 10 ms debounce, 250 ms first repeat, 50 ms repeat rate
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_PERIOD   = 2500000;
  localparam int DEF_CNT_W           = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

endpackage

// File: rtl/tetris_input_conditioner_button_channel.sv
// One button: 2-FF sync, debounce, rising-edge press pulse and optional auto-repeat.
module button_channel
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse,
  output logic cmd_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1, s2;
  logic             stable, stable_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  repeat_state_t    state, state_nxt;
  logic             rise, fall, rep_fire;

  // stable_d lags stable by one cycle so edges are visible for exactly one cycle
  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level only after it has persisted DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      stable_d <= stable;
      if (s2 != stable) begin
        if (cnt == DB_LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Repeat FSM next state; release wins over any pending repeat in the same cycle
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt + CNT_ONE;
    rep_fire  = 1'b0;
    case (state)
      IDLE: begin
        rcnt_nxt = '0;
        if (rise && REPEAT_EN) state_nxt = DELAY;
      end
      DELAY: begin
        if (rcnt == RD_LAST) begin
          rep_fire  = 1'b1;
          state_nxt = REPEAT;
          rcnt_nxt  = '0;
        end
      end
      REPEAT: begin
        if (rcnt == RP_LAST) begin
          rep_fire = 1'b1;
          rcnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
      end
    endcase
    if (fall) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
      rep_fire  = 1'b0;
    end
  end

  // FSM state and registered pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rcnt        <= '0;
      press_pulse <= 1'b0;
      cmd_pulse   <= 1'b0;
    end else begin
      state       <= state_nxt;
      rcnt        <= rcnt_nxt;
      press_pulse <= rise;
      cmd_pulse   <= rise | rep_fire;
    end
  end

endmodule

// File: rtl/tetris_input_conditioner.sv
// Six button channels, left/right cancellation and any_press merge, all outputs registered.
module tetris_input_conditioner
  import tetris_pkg::*;
#(
  parameter int           DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int           REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int           REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [5:0]   REPEAT_MASK     = 6'b000111,
  parameter int           CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] btn_raw,
  output logic       move_left,
  output logic       move_right,
  output logic       move_down,
  output logic       drop,
  output logic       rotate_right,
  output logic       rotate_left,
  output logic       any_press
);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] cmd;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[gi]),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[gi]),
      .press_pulse (press[gi]),
      .cmd_pulse   (cmd[gi])
    );
  end

  // Output register; simultaneous left+right cancel each other while both FSMs keep running
  always_ff @(posedge clk) begin
    if (reset) begin
      move_left    <= 1'b0;
      move_right   <= 1'b0;
      move_down    <= 1'b0;
      drop         <= 1'b0;
      rotate_right <= 1'b0;
      rotate_left  <= 1'b0;
      any_press    <= 1'b0;
    end else begin
      move_left    <= cmd[BTN_LEFT]  & ~cmd[BTN_RIGHT];
      move_right   <= cmd[BTN_RIGHT] & ~cmd[BTN_LEFT];
      move_down    <= cmd[BTN_DOWN];
      drop         <= cmd[BTN_DROP];
      rotate_right <= cmd[BTN_ROT_RIGHT];
      rotate_left  <= cmd[BTN_ROT_LEFT];
      any_press    <= |press;
    end
  end

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Directed bench: expected pulses queued with stimulus, popped as the DUT pulses.
module tb_tetris_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] btn_raw;
  logic       move_left, move_right, move_down, drop, rotate_right, rotate_left, any_press;
  logic [6:0] obs;

  tetris_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_MASK     (6'b000111),
    .CNT_W           (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .move_left    (move_left),
    .move_right   (move_right),
    .move_down    (move_down),
    .drop         (drop),
    .rotate_right (rotate_right),
    .rotate_left  (rotate_left),
    .any_press    (any_press)
  );

  always #5 clk = ~clk;

  // Output vector bits: 0 left, 1 right, 2 down, 3 drop, 4 rot_right, 5 rot_left, 6 any_press
  assign obs = {any_press, rotate_left, rotate_right, drop, move_down, move_right, move_left};

  localparam logic [6:0] V_L    = 7'b0000001;
  localparam logic [6:0] V_D    = 7'b0000100;
  localparam logic [6:0] V_DROP = 7'b0001000;
  localparam logic [6:0] V_RL   = 7'b0100000;
  localparam logic [6:0] V_ANY  = 7'b1000000;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } exp_t;

  exp_t q[$];
  exp_t e_pop;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;
  bit   mon_en = 1'b0;

  // cyc = number of posedges seen; a value driven at a negedge is sampled at edge cyc
  always @(posedge clk) cyc <= cyc + 1;

  // Every nonzero output cycle must match the head of the expectation queue
  always @(negedge clk) begin
    if (mon_en && obs !== 7'd0) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse cycle=%0d observed=%b required=none", cyc - 1, obs);
      end
      if (q.size() != 0) begin
        e_pop = q.pop_front();
        checks++;
        assert ((cyc - 1) === e_pop.cyc) else begin
          errors++;
          $error("FAIL pulse_cycle observed=%0d required=%0d", cyc - 1, e_pop.cyc);
        end
        checks++;
        assert (obs === e_pop.vec) else begin
          errors++;
          $error("FAIL pulse_vec cycle=%0d observed=%b required=%b", cyc - 1, obs, e_pop.vec);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int rel, input logic [6:0] v);
    q.push_back(exp_t'{t0 + rel, v});
  endtask

  task automatic drained(input string tag);
    checks++;
    assert (q.size() === 0) else begin
      errors++;
      $error("FAIL %s missing_pulses observed=%0d required=0", tag, q.size());
    end
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    btn_raw = 6'd0;
    step(3);
    reset = 1'b0;
    step(2);
    checks++;
    assert (obs === 7'd0) else begin
      errors++;
      $error("FAIL reset_state observed=%b required=0000000", obs);
    end
    mon_en = 1'b1;

    // 1: clean drop press, single pulse at 7, nothing on release
    t0 = cyc;
    btn_raw[3] = 1'b1;
    expect_at(7, V_DROP | V_ANY);
    step(50);
    btn_raw[3] = 1'b0;
    step(20);
    drained("t1_drop");

    // 2: left bounces for 12 cycles, then held from rel 12; released before the first repeat
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      btn_raw[0] = (i % 2 == 0);
      step(2);
    end
    btn_raw[0] = 1'b1;
    expect_at(19, V_L | V_ANY);
    step(8);
    btn_raw[0] = 1'b0;
    step(20);
    drained("t2_bounce");

    // 3: left held; released at 37 so the last repeat is at 41
    t0 = cyc;
    btn_raw[0] = 1'b1;
    expect_at(7, V_L | V_ANY);
    expect_at(17, V_L);
    for (int k = 20; k <= 41; k += 3) expect_at(k, V_L);
    step(37);
    btn_raw[0] = 1'b0;
    step(20);
    drained("t3_repeat");

    // 4: left+right together cancel; right released at 25, left resumes at 32 alone
    t0 = cyc;
    btn_raw[1:0] = 2'b11;
    expect_at(7, V_ANY);
    for (int k = 32; k <= 44; k += 3) expect_at(k, V_L);
    step(25);
    btn_raw[1] = 1'b0;
    step(15);
    btn_raw[0] = 1'b0;
    step(20);
    drained("t4_oppose");

    // 5: down held through reset at edges 20-21; fresh press at 29
    t0 = cyc;
    btn_raw[2] = 1'b1;
    expect_at(7, V_D | V_ANY);
    expect_at(17, V_D);
    step(20);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    expect_at(29, V_D | V_ANY);
    expect_at(39, V_D);
    for (int k = 42; k <= 54; k += 3) expect_at(k, V_D);
    step(28);
    btn_raw[2] = 1'b0;
    step(20);
    drained("t5_reset");

    // 6: rot_right glitch rejected; rot_left single pulse, no repeats
    btn_raw[4] = 1'b1;
    step(2);
    btn_raw[4] = 1'b0;
    step(10);
    t0 = cyc;
    btn_raw[5] = 1'b1;
    expect_at(7, V_RL | V_ANY);
    step(30);
    btn_raw[5] = 1'b0;
    step(20);
    drained("t6_rotate");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
